outerprodrc_tile: RTL and testbench
===================================

Name: outerprodrc_tile

Overview:
Parametrised, self-sequencing successor of the rate-coded outer-product GEMM tile. It latches a HIDDEN x ROWNUM row operand block and a HIDDEN x COLNUM column operand block. It generates deterministic unary bitstreams internally over a fixed window and reduces signed product bits across HIDDEN each cycle. Results go into ROWNUM x COLNUM saturating signed binary accumulators. It sits between operand buffers and the output writeback, and adds a start/done handshake, stall, and cross-tile accumulation for K-tiling.

Parameters:
ROWNUM, 2, rows of output tile
COLNUM, 2, columns of output tile
HIDDEN, 2, reduction depth per tile
BITWIDTH, 4, two's-complement operand width; window L = 2^(BITWIDTH-1) cycles
OUTBITWIDTH, 8, two's-complement accumulator width; must be >= clog2(HIDDEN+1)+1

Ports:
iClk  in  1  clock
iRstN  in  1  asynchronous active-low reset
iEn  in  1  run enable; low freezes window counter and accumulators
iClr  in  1  synchronous clear of accumulators, returns FSM to IDLE
iStart  in  1  start request, sampled in IDLE only
iAcc  in  1  sampled with iStart; 1 = keep accumulator contents, 0 = zero them at start
iData0  in  HIDDEN*ROWNUM*BITWIDTH  row operands, element (h,r) at [(h*ROWNUM+r)*BITWIDTH +: BITWIDTH]
iData1  in  HIDDEN*COLNUM*BITWIDTH  column operands, element (h,c) at [(h*COLNUM+c)*BITWIDTH +: BITWIDTH]
oBusy  out  1  high in RUN and DONE
oDone  out  1  one-cycle pulse when tile result is final
oData  out  ROWNUM*COLNUM*OUTBITWIDTH  accumulators, element (r,c) at [(r*COLNUM+c)*OUTBITWIDTH +: OUTBITWIDTH], registered

Behaviour:
- Reset (async, iRstN=0): FSM=IDLE, window counter cnt=0, operand latches=0, oData=0, oBusy=0, oDone=0. Reset mid-RUN abandons the tile with no partial result retained.
- FSM states are IDLE, RUN and DONE.
- IDLE: if iStart=1, latch iData0/iData1, set cnt=0, go to RUN. If iAcc=0, zero all accumulators on that same edge; otherwise hold them. iStart outside IDLE is ignored.
- RUN: on each edge with iEn=1, update accumulators and increment cnt. When the edge processes cnt=L-1, go to DONE. With iEn=0, hold all state.
- DONE: oDone=1 for exactly one cycle, then IDLE. oData is stable from DONE until the next start or clear. A back-to-back iStart is accepted in the IDLE cycle that follows.
- iClr has priority over everything except reset: accumulators=0, cnt=0, FSM=IDLE, no oDone pulse.
- Magnitude: |x| per operand. The most-negative value (-2^(BITWIDTH-1)) saturates to L-1.
- Sign: s = sign(a) XOR sign(b).
- Row bit at count cnt: rb = (|a| > cnt), i.e. temporal/thermometer coding.
- Column bit at count cnt: cb = (|b| > bitrev(cnt)), where bitrev reverses the BITWIDTH-1 bits of cnt (rate coding).
- Product bit: p = rb AND cb, signed by s, giving -1, 0 or +1.
- Per-cycle delta(r,c) = sum over h of the signed p, range [-HIDDEN, +HIDDEN], computed combinationally at OUTBITWIDTH width.
- Accumulator update: acc <= sat(acc + delta), saturating to [-2^(OUTBITWIDTH-1), 2^(OUTBITWIDTH-1)-1]. There is no wrap-around.
- Latency: start edge, then L enabled RUN edges, then DONE, so oDone occurs L+1 cycles after start when iEn is held high.

Test Plan:
- Params 2/2/2/4/8 (ROWNUM/COLNUM/HIDDEN/BITWIDTH/OUTBITWIDTH). All a=+4, all b=+4, iAcc=0, iEn=1 -> each oData element = 2+2 = 4. oDone pulses exactly 9 cycles after the iStart edge.
- a(h0)=+7, b(h0)=+7, h1 operands 0 -> 7 for every element. Repeat with a(h0)=-3, b(h0)=+5 -> -3 for every element.
- Repeat the all-+7 tile (delta sum 14) with iAcc=1: after 9 tiles oData=126, and the 10th tile saturates at 127. With a=-7, b=+7, oData floors at -128.
- iEn toggled low for 3 cycles mid-RUN -> identical final result, with oDone delayed by exactly 3 cycles. iStart pulsed during RUN is ignored.
- iClr asserted mid-RUN -> oData=0 on the next cycle, FSM returns to IDLE, no oDone. iRstN dropped mid-RUN -> all outputs 0 immediately (asynchronously).
- a=-8 (most-negative), b=+7 -> magnitude clamped to 7, result -7.

Source files
------------

// File: rtl/outerprodrc_tile.sv
// outerprodrc_tile: self-sequencing rate-coded outer-product GEMM tile.
// Unary row/column streams, signed per-cycle reduction, saturating accumulators.
module outerprodrc_tile #(
  parameter int ROWNUM      = 2,
  parameter int COLNUM      = 2,
  parameter int HIDDEN      = 2,
  parameter int BITWIDTH    = 4,
  parameter int OUTBITWIDTH = 8
) (
  input  logic                                 iClk,
  input  logic                                 iRstN,
  input  logic                                 iEn,
  input  logic                                 iClr,
  input  logic                                 iStart,
  input  logic                                 iAcc,
  input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    iData0,
  input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]    iData1,
  output logic                                 oBusy,
  output logic                                 oDone,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

  localparam int CW = BITWIDTH - 1;
  localparam int OW = OUTBITWIDTH;
  localparam logic [OW-1:0] ONE  = OW'(1);
  localparam logic [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                               state_q;
  logic [CW-1:0]                        cnt_q;
  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    a_q;
  logic [HIDDEN*COLNUM*BITWIDTH-1:0]    b_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic [ROWNUM*COLNUM*OW-1:0]          acc_q;
  logic [ROWNUM*COLNUM*OW-1:0]          acc_d;

  logic          start;
  logic          step;
  logic [CW-1:0] rev;
  logic [BITWIDTH-1:0] ea;
  logic [BITWIDTH-1:0] eb;
  logic [OW-1:0] delta;
  logic [OW-1:0] cur;
  logic [OW-1:0] sum;
  logic [OW:0]   wide;

  // Magnitude; the most-negative code clamps to L-1 so it fits CW bits.
  function automatic logic [CW-1:0] mag(input logic [BITWIDTH-1:0] x);
    logic [BITWIDTH-1:0] n;
    n = ~x + BITWIDTH'(1);
    if (!x[BITWIDTH-1]) return x[CW-1:0];
    if (n[BITWIDTH-1]) return {CW{1'b1}};
    return n[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] x);
    logic [CW-1:0] y;
    for (int k = 0; k < CW; k++) y[k] = x[CW-1-k];
    return y;
  endfunction

  assign start = (state_q == S_IDLE) && iStart;
  assign step  = (state_q == S_RUN) && iEn;

  // Control FSM: operand latch, window counter and registered status.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (iClr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (iStart) begin
            a_q     <= iData0;
            b_q     <= iData1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (iEn) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == {CW{1'b1}}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-cycle signed reduction across HIDDEN and saturating add.
  always_comb begin
    acc_d = acc_q;
    rev   = bitrev(cnt_q);
    ea    = '0;
    eb    = '0;
    delta = '0;
    cur   = '0;
    sum   = '0;
    wide  = '0;
    for (int r = 0; r < ROWNUM; r++) begin
      for (int c = 0; c < COLNUM; c++) begin
        delta = '0;
        for (int h = 0; h < HIDDEN; h++) begin
          ea = a_q[(h*ROWNUM+r)*BITWIDTH +: BITWIDTH];
          eb = b_q[(h*COLNUM+c)*BITWIDTH +: BITWIDTH];
          if ((mag(ea) > cnt_q) && (mag(eb) > rev)) begin
            if (ea[BITWIDTH-1] ^ eb[BITWIDTH-1])
              delta = delta - ONE;
            else
              delta = delta + ONE;
          end
        end
        cur  = acc_q[(r*COLNUM+c)*OW +: OW];
        wide = {cur[OW-1], cur} + {delta[OW-1], delta};
        if (wide[OW] != wide[OW-1])
          sum = wide[OW] ? SMIN : SMAX;
        else
          sum = wide[OW-1:0];
        acc_d[(r*COLNUM+c)*OW +: OW] = sum;
      end
    end
  end

  // Accumulators: clear, zero-on-start, or step while running.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      acc_q <= '0;
    else if (iClr)
      acc_q <= '0;
    else if (start && !iAcc)
      acc_q <= '0;
    else if (step)
      acc_q <= acc_d;
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oData = acc_q;

endmodule

// File: tb/tb_outerprodrc_tile.sv
// tb_outerprodrc_tile: randomized self-checking bench for outerprodrc_tile.
// Reference model computes unary streams from integer arithmetic.
module tb_outerprodrc_tile;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int H  = 2;
  localparam int BW = 4;
  localparam int OW = 8;
  localparam int CW = BW - 1;
  localparam int L  = 1 << CW;
  localparam int MAXV = (1 << (OW-1)) - 1;
  localparam int MINV = -(1 << (OW-1));

  logic iClk = 1'b0;
  logic iRstN = 1'b0;
  logic iEn = 1'b0;
  logic iClr = 1'b0;
  logic iStart = 1'b0;
  logic iAcc = 1'b0;
  logic [H*R*BW-1:0] iData0 = '0;
  logic [H*C*BW-1:0] iData1 = '0;
  logic oBusy;
  logic oDone;
  logic [R*C*OW-1:0] oData;

  int checks = 0;
  int errors = 0;
  int ma[H][R];
  int mb[H][C];
  int exp_acc[R][C];

  always #5 iClk = ~iClk;

  outerprodrc_tile #(
    .ROWNUM(R), .COLNUM(C), .HIDDEN(H),
    .BITWIDTH(BW), .OUTBITWIDTH(OW)
  ) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr),
    .iStart(iStart), .iAcc(iAcc),
    .iData0(iData0), .iData1(iData1),
    .oBusy(oBusy), .oDone(oDone), .oData(oData)
  );

  function automatic int magn(int x);
    int m;
    m = (x < 0) ? -x : x;
    return (m > L-1) ? L-1 : m;
  endfunction

  function automatic int brev(int t);
    int v;
    v = 0;
    for (int k = 0; k < CW; k++)
      v = v | (((t >> k) & 1) << (CW-1-k));
    return v;
  endfunction

  function automatic int outv(int r, int c);
    logic [OW-1:0] v;
    v = oData[(r*C+c)*OW +: OW];
    return int'($signed(v));
  endfunction

  task automatic drive_ops();
    for (int h = 0; h < H; h++) begin
      for (int r = 0; r < R; r++) iData0[(h*R+r)*BW +: BW] = BW'(ma[h][r]);
      for (int c = 0; c < C; c++) iData1[(h*C+c)*BW +: BW] = BW'(mb[h][c]);
    end
  endtask

  task automatic set_all(int a0, int b0, int a1, int b1);
    for (int r = 0; r < R; r++) begin ma[0][r] = a0; ma[1][r] = a1; end
    for (int c = 0; c < C; c++) begin mb[0][c] = b0; mb[1][c] = b1; end
  endtask

  task automatic randomize_ops();
    for (int h = 0; h < H; h++) begin
      for (int r = 0; r < R; r++) ma[h][r] = int'($urandom_range(0, 15)) - 8;
      for (int c = 0; c < C; c++) mb[h][c] = int'($urandom_range(0, 15)) - 8;
    end
  endtask

  // Model: walk the window, count coincident unary bits, clamp each cycle.
  task automatic model_tile(input bit keep);
    int d;
    int s;
    if (!keep)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) exp_acc[r][c] = 0;
    for (int t = 0; t < L; t++) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          d = 0;
          for (int h = 0; h < H; h++)
            if (magn(ma[h][r]) > t && magn(mb[h][c]) > brev(t))
              d += ((ma[h][r] < 0) != (mb[h][c] < 0)) ? -1 : 1;
          s = exp_acc[r][c] + d;
          if (s > MAXV) s = MAXV;
          if (s < MINV) s = MINV;
          exp_acc[r][c] = s;
        end
      end
    end
  endtask

  task automatic run_tile(input bit keep, input int stall_at,
                          input int stall_len, input int pulse_at,
                          output int cycles);
    int n;
    @(negedge iClk);
    drive_ops();
    iAcc = keep;
    iStart = 1'b1;
    iEn = 1'b1;
    @(posedge iClk);
    n = 1;
    @(negedge iClk);
    iStart = 1'b0;
    iAcc = 1'b0;
    iData0 = (H*R*BW)'($urandom);
    iData1 = (H*C*BW)'($urandom);
    while (!oDone && n < 40) begin
      iEn = !(stall_at >= 0 && n >= stall_at && n < stall_at + stall_len);
      iStart = (n == pulse_at);
      @(posedge iClk);
      n++;
      @(negedge iClk);
      iStart = 1'b0;
      iEn = 1'b1;
    end
    cycles = oDone ? n : -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge iClk);
    checks++;
    if (oData !== '0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h busy=%b done=%b required 0/0/0",
               oData, oBusy, oDone);
    end
    iRstN = 1'b1;
    iEn = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    set_all(4, 4, 4, 4);
    run_tile(1'b0, -1, 0, -1, cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 9", cyc);
    end
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_done: busy=%b required 1", oBusy);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (outv(r, c) !== 4) begin
          errors++;
          $display("FAIL basic_val(%0d,%0d): got %0d required 4",
                   r, c, outv(r, c));
        end
      end
    @(negedge iClk);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b required 0/0", oDone, oBusy);
    end
  endtask

  task automatic test_patterns();
    int cyc;
    int av[3];
    int bv[3];
    int ev[3];
    av = '{7, -3, -8};
    bv = '{7, 5, 7};
    ev = '{7, -3, -7};
    for (int p = 0; p < 3; p++) begin
      set_all(av[p], bv[p], 0, 0);
      run_tile(1'b0, -1, 0, -1, cyc);
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          checks++;
          if (cyc !== 9 || outv(r, c) !== ev[p]) begin
            errors++;
            $display("FAIL pattern%0d(%0d,%0d): got %0d cyc %0d required %0d cyc 9",
                     p, r, c, outv(r, c), cyc, ev[p]);
          end
        end
    end
  endtask

  task automatic test_saturate();
    int cyc;
    int want;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_all(7, 7, 7, 7);
      else set_all(-7, 7, -7, 7);
      for (int t = 0; t < 10; t++) begin
        run_tile(t != 0, -1, 0, -1, cyc);
        checks++;
        if (cyc !== 9) begin
          errors++;
          $display("FAIL sat_latency p%0d t%0d: got %0d required 9", pass, t, cyc);
        end
        if (t >= 8) begin
          if (pass == 0) want = (t == 8) ? 126 : 127;
          else want = (t == 8) ? -126 : -128;
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
              checks++;
              if (outv(r, c) !== want) begin
                errors++;
                $display("FAIL sat p%0d tile%0d (%0d,%0d): got %0d required %0d",
                         pass, t + 1, r, c, outv(r, c), want);
              end
            end
        end
      end
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_acc[r][c] = MINV;
  endtask

  task automatic test_clear();
    bit seen;
    set_all(7, 7, 7, 7);
    @(negedge iClk);
    drive_ops();
    iAcc = 1'b1;
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    iAcc = 1'b0;
    repeat (3) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    checks++;
    if (oData !== '0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL clear: data=%h busy=%b required 0/0", oData, oBusy);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge iClk);
      if (oDone) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clear_nodone: done seen=%b required 0", seen);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_acc[r][c] = 0;
  endtask

  task automatic test_stall();
    int cyc;
    randomize_ops();
    model_tile(1'b0);
    run_tile(1'b0, 3, 3, 2, cyc);
    checks++;
    if (cyc !== 12) begin
      errors++;
      $display("FAIL stall_latency: got %0d required 12", cyc);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (outv(r, c) !== exp_acc[r][c]) begin
          errors++;
          $display("FAIL stall_val(%0d,%0d): got %0d required %0d",
                   r, c, outv(r, c), exp_acc[r][c]);
        end
      end
  endtask

  task automatic test_async_reset();
    set_all(7, 7, 7, 7);
    @(negedge iClk);
    drive_ops();
    iAcc = 1'b1;
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    iAcc = 1'b0;
    repeat (3) @(negedge iClk);
    #2 iRstN = 1'b0;
    #1;
    checks++;
    if (oData !== '0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h busy=%b done=%b required 0/0/0",
               oData, oBusy, oDone);
    end
    @(negedge iClk);
    iRstN = 1'b1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_acc[r][c] = 0;
  endtask

  task automatic test_random();
    int cyc;
    bit keep;
    for (int t = 0; t < 8; t++) begin
      randomize_ops();
      keep = 1'($urandom_range(0, 1));
      model_tile(keep);
      run_tile(keep, -1, 0, -1, cyc);
      checks++;
      if (cyc !== 9) begin
        errors++;
        $display("FAIL rand_latency t%0d: got %0d required 9", t, cyc);
      end
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          checks++;
          if (outv(r, c) !== exp_acc[r][c]) begin
            errors++;
            $display("FAIL rand t%0d (%0d,%0d): got %0d required %0d",
                     t, r, c, outv(r, c), exp_acc[r][c]);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_saturate();
    test_clear();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
